// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges ID/MEM stall requests with a multi-cycle EX sequencer and counts stall cycles
// Ports:
//   clk, rst (async, active-low)
//   id_stall_req  - load-use hazard in ID
//   ex_mc_start   - EX holds a multi-cycle op; ex_mc_len (latency L) sampled with it
//   ex_mc_abort   - cancel of the multi-cycle op
//   mem_stall_req - data-memory wait state
//   ctrl_stall    - hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved
//   ex_mc_done    - multi-cycle result valid
//   mc_busy       - sequencer not idle
//   stall_cnt     - saturating count of cycles with the PC held
module pipe_stall_ctrl #(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stall_req,
  input  logic               ex_mc_start,
  input  logic [CNT_W-1:0]   ex_mc_len,
  input  logic               ex_mc_abort,
  input  logic               mem_stall_req,
  output logic [STALL_W-1:0] ctrl_stall,
  output logic               ex_mc_done,
  output logic               mc_busy,
  output logic [PERF_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ex_stall;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ctrl_stall[0] && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  // The unit keeps counting through MEM wait states; only DONE waits on MEM so the result is not lost.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (ex_mc_start && !ex_mc_abort) begin
        state_d = (ex_mc_len == '0) ? DONE : BUSY;
        cnt_d   = ex_mc_len;
      end
      BUSY: begin
        cnt_d   = ex_mc_abort ? '0 : cnt_q - 1'b1;
        state_d = ex_mc_abort ? IDLE : (cnt_q == CNT_W'(1)) ? DONE : BUSY;
      end
      DONE: state_d = (ex_mc_abort || !mem_stall_req) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign ex_stall   = !ex_mc_abort && ((state_q == IDLE && ex_mc_start) || state_q == BUSY);
  // Requests are masked while reset is held so the pipeline sees no stall.
  assign ctrl_stall = !rst          ? '0 :
                      mem_stall_req ? STALL_W'(5'b11111) :
                      ex_stall      ? STALL_W'(4'b1111) :
                      id_stall_req  ? STALL_W'(3'b111) : '0;
  assign ex_mc_done = (state_q == DONE);
  assign mc_busy    = (state_q != IDLE);
endmodule
